mantissa_aligner: RTL and testbench

Multi-cycle alignment stage of the add/sub datapath, directly downstream of the exponent-difference stage. It consumes that stage's clamped shift amount (`Difference`), its `Sign` flag, the two exponents, and the two significands. It right-shifts the smaller-exponent significand by up to `ShiftStep` bits per cycle, collecting guard, round and sticky bits. It hands the aligned pair to the significand adder over a valid/ready handshake.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/align_shift_step.sv | 21 ++
 rtl/mantissa_aligner.sv | 96 +++++++++
 tb/tb_mantissa_aligner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU format constants, alignment limits and the aligner state type
package fpu_pkg;
  localparam int HALF_EXP = 5;
  localparam int HALF_MANT = 10;
  localparam int SINGLE_EXP = 8;
  localparam int SINGLE_MANT = 23;
  localparam int DOUBLE_EXP = 11;
  localparam int DOUBLE_MANT = 52;
  localparam int MAX_ALIGN_SHIFT = SINGLE_MANT + 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} align_state_t;
  function automatic int max_align_shift(input int mant);
    return mant + 4;
  endfunction
endpackage

// File: rtl/align_shift_step.sv
// align_shift_step: one bounded right-shift step with OR of the bits shifted out (FPU_ALIGN_STICKY_EN)
module align_shift_step #(
  parameter int W = 26,
  parameter int STEP = 4,
  parameter int AW = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  din,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  dout
`ifdef FPU_ALIGN_STICKY_EN
  , output logic        lost
`endif
);
  // zeros enter at the MSB; lost collects whatever falls off bit 0
  always_comb begin
    dout = din >> amt;
`ifdef FPU_ALIGN_STICKY_EN
    lost = |(din & ~({W{1'b1}} << amt));
`endif
  end
endmodule

// File: rtl/mantissa_aligner.sv
// mantissa_aligner: multi-cycle significand alignment with guard/round/sticky (sticky gated by FPU_ALIGN_STICKY_EN)
module mantissa_aligner #(
  parameter int ExponentSize = 8,
  parameter int MantissaSize = 23,
  parameter int ShiftStep = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [ExponentSize-1:0]   Exponent1,
  input  logic [ExponentSize-1:0]   Exponent2,
  input  logic [MantissaSize:0]     Mantissa1,
  input  logic [MantissaSize:0]     Mantissa2,
  input  logic [ExponentSize-4:0]   Difference,
  input  logic                      Sign,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [MantissaSize:0]     LargeMantissa,
  output logic [MantissaSize+2:0]   AlignedMantissa,
  output logic                      Sticky,
  output logic [ExponentSize-1:0]   CommonExponent,
  output logic                      Swapped
);
  import fpu_pkg::*;
  localparam int W = MantissaSize + 3;
  localparam int MAX = max_align_shift(MantissaSize);
  localparam int RW = $clog2(MAX + 1);
  localparam int SW = $clog2(ShiftStep + 1);
  align_state_t state;
  logic [RW-1:0] rem, rem_load;
  logic [SW-1:0] step;
  logic [W-1:0] work, work_next;
`ifdef FPU_ALIGN_STICKY_EN
  logic lost, sticky_q;
`endif
  // clamp the incoming distance and pick this cycle's step size
  always_comb begin
    rem_load = RW'(32'(Difference) > 32'(MAX) ? 32'(MAX) : 32'(Difference));
    step = SW'(32'(rem) > 32'(ShiftStep) ? 32'(ShiftStep) : 32'(rem));
  end
  align_shift_step #(.W(W), .STEP(ShiftStep), .AW(SW)) u_step (
    .din  (work),
    .amt  (step),
    .dout (work_next)
`ifdef FPU_ALIGN_STICKY_EN
    , .lost (lost)
`endif
  );
  // accept in IDLE, shift until nothing remains, hold the result until taken
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      rem <= '0;
      work <= '0;
      LargeMantissa <= '0;
      CommonExponent <= '0;
      Swapped <= 1'b0;
`ifdef FPU_ALIGN_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (InValid) begin
          LargeMantissa <= Sign ? Mantissa1 : Mantissa2;
          work <= {Sign ? Mantissa2 : Mantissa1, 2'b00};
          CommonExponent <= Sign ? Exponent1 : Exponent2;
          Swapped <= ~Sign;
          rem <= rem_load;
`ifdef FPU_ALIGN_STICKY_EN
          sticky_q <= 1'b0;
`endif
          state <= (rem_load == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          work <= work_next;
          rem <= rem - RW'(step);
`ifdef FPU_ALIGN_STICKY_EN
          sticky_q <= sticky_q | lost;
`endif
          state <= (rem == RW'(step)) ? DONE : SHIFT;
        end
        DONE: if (OutReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign InReady = state == IDLE;
  assign OutValid = state == DONE;
  assign AlignedMantissa = work;
`ifdef FPU_ALIGN_STICKY_EN
  assign Sticky = sticky_q;
`else
  assign Sticky = 1'b0;
`endif
endmodule

// File: tb/tb_mantissa_aligner.sv
// tb_mantissa_aligner: table-driven scoreboard bench for mantissa_aligner
module tb_mantissa_aligner;
  logic Clk = 1'b0, Reset = 1'b1, InValid = 1'b0, OutReady = 1'b0, Sign = 1'b0;
  logic InReady, OutValid, Sticky, Swapped;
  logic [7:0] Exponent1 = '0, Exponent2 = '0, CommonExponent;
  logic [23:0] Mantissa1 = '0, Mantissa2 = '0, LargeMantissa;
  logic [4:0] Difference = '0;
  logic [25:0] AlignedMantissa;
  int checks = 0, passed = 0;

  typedef struct {logic [7:0] e1, e2; logic [23:0] m1, m2; logic [4:0] diff; logic sign;} vec_t;
  typedef struct {logic [25:0] al; logic [23:0] lg; logic [7:0] ce; logic st, sw; int lat;} exp_t;
  exp_t sb[$];
  vec_t tbl[10];

  mantissa_aligner dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Exponent1(Exponent1), .Exponent2(Exponent2), .Mantissa1(Mantissa1), .Mantissa2(Mantissa2),
    .Difference(Difference), .Sign(Sign), .OutValid(OutValid), .OutReady(OutReady),
    .LargeMantissa(LargeMantissa), .AlignedMantissa(AlignedMantissa), .Sticky(Sticky),
    .CommonExponent(CommonExponent), .Swapped(Swapped)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic [63:0] w;
    int d;
    d = (int'(v.diff) > 27) ? 27 : int'(v.diff);
    w = {38'd0, (v.sign ? v.m2 : v.m1), 2'b00};
    e.al = 26'(w >> d);
    e.lg = v.sign ? v.m1 : v.m2;
    e.ce = v.sign ? v.e1 : v.e2;
    e.sw = ~v.sign;
`ifdef FPU_ALIGN_STICKY_EN
    e.st = |(w & ((64'd1 << d) - 64'd1));
`else
    e.st = 1'b0;
`endif
    e.lat = 1 + (d + 3) / 4;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    Exponent1 = v.e1; Exponent2 = v.e2; Mantissa1 = v.m1; Mantissa2 = v.m2;
    Difference = v.diff; Sign = v.sign;
  endtask

  task automatic wait_valid(output int edges);
    edges = 1;
    while (!OutValid && edges < 40) begin
      @(posedge Clk); #1;
      edges++;
    end
  endtask

  task automatic compare_out(input int edges);
    exp_t g;
    chk("out_valid", OutValid, 1);
    chk("sb_nonempty", sb.size(), 1);
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk("latency", edges, g.lat);
      chk("aligned", AlignedMantissa, g.al);
      chk("large", LargeMantissa, g.lg);
      chk("common_exp", CommonExponent, g.ce);
      chk("sticky", Sticky, g.st);
      chk("swapped", Swapped, g.sw);
    end
    chk("in_ready_done", InReady, 0);
  endtask

  task automatic run_op(input vec_t v);
    int edges;
    drive(v);
    sb.push_back(model(v));
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    wait_valid(edges);
    compare_out(edges);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    chk("in_ready_idle", InReady, 1);
    chk("out_valid_idle", OutValid, 0);
  endtask

  initial begin
    vec_t v, v2;
    exp_t e;
    int edges;
    logic [25:0] held;
    tbl[0] = '{8'd130, 8'd128, 24'hC00000, 24'h800000, 5'd2, 1'b1};
    tbl[1] = '{8'd128, 8'd130, 24'hC00000, 24'h800000, 5'd2, 1'b0};
    tbl[2] = '{8'd130, 8'd125, 24'hC00000, 24'h800001, 5'd5, 1'b1};
    tbl[3] = '{8'd160, 8'd133, 24'h900000, 24'hFFFFFF, 5'd27, 1'b1};
    tbl[4] = '{8'd100, 8'd100, 24'h812345, 24'hABCDEF, 5'd0, 1'b1};
    tbl[5] = '{8'd90, 8'd121, 24'hFFFFFF, 24'h800000, 5'd31, 1'b0};
    tbl[6] = '{8'd50, 8'd46, 24'h80000F, 24'hC00000, 5'd4, 1'b0};
    tbl[7] = '{8'd77, 8'd76, 24'hA00000, 24'h800003, 5'd1, 1'b1};
    tbl[8] = '{8'd70, 8'd44, 24'h800000, 24'hFFFFFF, 5'd26, 1'b1};
    tbl[9] = '{8'd20, 8'd28, 24'h800080, 24'hF00000, 5'd8, 1'b0};
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", InReady, 1);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_aligned", AlignedMantissa, 0);
    chk("rst_large", LargeMantissa, 0);
    chk("rst_sticky", Sticky, 0);
    chk("rst_swapped", Swapped, 0);
    chk("rst_common_exp", CommonExponent, 0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 10; i++) run_op(tbl[i]);
    for (int i = 0; i < 8; i++) begin
      v.e1 = 8'($urandom); v.e2 = 8'($urandom);
      v.m1 = {1'b1, 23'($urandom)}; v.m2 = {1'b1, 23'($urandom)};
      v.diff = 5'($urandom_range(0, 31)); v.sign = 1'($urandom);
      run_op(v);
    end
    v = tbl[0];
    drive(v);
    e = model(v);
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    wait_valid(edges);
    chk("bp_out_valid", OutValid, 1);
    held = AlignedMantissa;
    v2 = tbl[3];
    drive(v2);
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("bp_hold_valid", OutValid, 1);
      chk("bp_hold_in_ready", InReady, 0);
      chk("bp_hold_aligned", AlignedMantissa, e.al);
      chk("bp_hold_large", LargeMantissa, e.lg);
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    chk("bp_release_in_ready", InReady, 1);
    chk("bp_release_out_valid", OutValid, 0);
    chk("bp_no_second_accept", AlignedMantissa, held);
    drive(tbl[3]);
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("mid_shift_busy", InReady, 0);
    Reset = 1'b1;
    #1;
    chk("abort_out_valid", OutValid, 0);
    chk("abort_in_ready", InReady, 1);
    chk("abort_aligned", AlignedMantissa, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("abort_no_output", OutValid, 0);
    run_op(tbl[2]);
    run_op(tbl[3]);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
